// File: rtl/tlb_lookup_pipe_pkg.sv
// Shared CPU definitions for the TLB lookup path.
// Holds address widths, the TLB entry/page layout, lookup types, exception
// codes, the lookup response record and address mask helpers.
package cpu_defs;

    localparam int VALEN         = 32;
    localparam int PALEN         = 32;
    localparam int TLB_ENTRY_NUM = 16;
    localparam int TLB_IDX_W     = $clog2(TLB_ENTRY_NUM);

    typedef logic [VALEN-1:0] virt_t;
    typedef logic [PALEN-1:0] phys_t;
    typedef logic [9:0]       asid_t;
    typedef logic [1:0]       plv_t;
    typedef logic [1:0]       mat_t;
    typedef logic [5:0]       ecode_t;

    localparam ecode_t ECODE_NONE = 6'h00;
    localparam ecode_t ECODE_PIL  = 6'h01;
    localparam ecode_t ECODE_PIS  = 6'h02;
    localparam ecode_t ECODE_PIF  = 6'h03;
    localparam ecode_t ECODE_PME  = 6'h04;
    localparam ecode_t ECODE_PPI  = 6'h07;
    localparam ecode_t ECODE_TLBR = 6'h3F;

    typedef enum logic [1:0] {
        LOOKUP_FETCH = 2'd0,
        LOOKUP_LOAD  = 2'd1,
        LOOKUP_STORE = 2'd2
    } tlb_lookup_type_t;

    // One half of an entry; ppn is the physical address in 4KB units.
    typedef struct packed {
        logic [PALEN-13:0] ppn;
        plv_t              plv;
        mat_t              mat;
        logic              d;
        logic              v;
    } tlb_page_t;

    // vppn is va[VALEN-1:13]; ps is log2 of the page size (12..30).
    typedef struct packed {
        logic [VALEN-14:0] vppn;
        logic [5:0]        ps;
        logic              g;
        asid_t             asid;
        logic              e;
        tlb_page_t         p0;
        tlb_page_t         p1;
    } tlb_entry_t;

    // Permission bits of the selected page, used for exception checks.
    typedef struct packed {
        plv_t plv;
        logic d;
        logic v;
    } tlb_perm_t;

    typedef struct packed {
        phys_t                pa;
        mat_t                 mat;
        ecode_t               ecode;
        logic                 is_exc;
        logic                 multi_hit;
        logic [TLB_IDX_W-1:0] idx;
    } tlb_resp_t;

    // Bits strictly above ps: the VPN compare region of an even/odd pair.
    function automatic logic [VALEN-1:0] above_mask(input logic [5:0] ps);
        logic [VALEN-1:0] m;
        for (int i = 0; i < VALEN; i++) begin
            m[i] = (i > int'(ps));
        end
        return m;
    endfunction

    // Bits strictly below ps: the page offset passed through from va.
    function automatic logic [VALEN-1:0] below_mask(input logic [5:0] ps);
        logic [VALEN-1:0] m;
        for (int i = 0; i < VALEN; i++) begin
            m[i] = (i < int'(ps));
        end
        return m;
    endfunction

endpackage

// File: rtl/tlb_lookup_pipe_match.sv
// tlb_match: combinational single-port TLB search.
// Ports: entrys/asid/va in; hit vector, lowest matching index, multi_hit,
// selected page permissions, translated pa and mat out.
module tlb_match
    import cpu_defs::*;
#(
    parameter int ENTRY_NUM = TLB_ENTRY_NUM
) (
    input  tlb_entry_t             entrys [ENTRY_NUM],
    input  asid_t                  asid,
    input  virt_t                  va,
    output logic [ENTRY_NUM-1:0]   hit,
    output logic [TLB_IDX_W-1:0]   hit_idx,
    output logic                   multi_hit,
    output tlb_perm_t              sel_perm,
    output phys_t                  pa,
    output mat_t                   mat
);

    logic [5:0]       sel_ps;
    tlb_page_t        sel_p0;
    tlb_page_t        sel_p1;
    tlb_page_t        page;
    logic [VALEN-1:0] lo;
    logic             found;

    // Per-entry match: enabled, ASID or global, VPN equal above bit ps.
    always_comb begin
        hit = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            hit[i] = entrys[i].e
                   & (entrys[i].g | (entrys[i].asid == asid))
                   & (((va ^ {entrys[i].vppn, 13'b0}) & above_mask(entrys[i].ps)) == '0);
        end
    end

    // Lowest index wins: scan downward so the smallest hit is written last.
    always_comb begin
        hit_idx = '0;
        sel_ps  = 6'd0;
        sel_p0  = '0;
        sel_p1  = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            hit_idx = hit[i] ? TLB_IDX_W'(i) : hit_idx;
            sel_ps  = hit[i] ? entrys[i].ps : sel_ps;
            sel_p0  = hit[i] ? entrys[i].p0 : sel_p0;
            sel_p1  = hit[i] ? entrys[i].p1 : sel_p1;
        end
    end

    // Odd/even page by va[ps]; pa takes frame bits at and above ps.
    always_comb begin
        found     = |hit;
        multi_hit = |(hit & (hit - ENTRY_NUM'(1)));
        lo        = below_mask(sel_ps);
        if (found) begin
            page = va[sel_ps[4:0]] ? sel_p1 : sel_p0;
            pa   = ({page.ppn, 12'b0} & ~lo) | (va & lo);
        end else begin
            page = '0;
            pa   = '0;
        end
        mat      = page.mat;
        sel_perm = '{plv: page.plv, d: page.d, v: page.v};
    end

endmodule

// File: rtl/tlb_lookup_pipe.sv
// tlb_lookup_pipe: multi-port, 2-stage TLB lookup pipeline.
// Ports: clk/rst; live TLB contents and CSR state (asid, plv, da_mode,
// da_mat); flush; per-port request (req_valid/req_ready/req_va/req_type)
// and response (resp_valid/resp_ready/resp) handshakes.
// S1 holds the request, S2 holds the registered translation result.
module tlb_lookup_pipe
    import cpu_defs::*;
#(
    parameter int ENTRY_NUM = TLB_ENTRY_NUM,
    parameter int PORT_NUM  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  tlb_entry_t            entrys [ENTRY_NUM],
    input  asid_t                 asid,
    input  plv_t                  plv,
    input  logic                  da_mode,
    input  mat_t                  da_mat,
    input  logic                  flush,
    input  logic [PORT_NUM-1:0]   req_valid,
    output logic [PORT_NUM-1:0]   req_ready,
    input  virt_t                 req_va   [PORT_NUM],
    input  tlb_lookup_type_t      req_type [PORT_NUM],
    output logic [PORT_NUM-1:0]   resp_valid,
    input  logic [PORT_NUM-1:0]   resp_ready,
    output tlb_resp_t             resp     [PORT_NUM]
);

    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_port
        logic                  s1_valid;
        virt_t                 s1_va;
        tlb_lookup_type_t      s1_type;
        logic                  s2_valid;
        tlb_resp_t             s2_resp;
        logic                  s1_adv;
        logic                  s2_adv;
        tlb_resp_t             result;
        logic [ENTRY_NUM-1:0]  m_hit;
        logic [TLB_IDX_W-1:0]  m_idx;
        logic                  m_multi;
        tlb_perm_t             m_perm;
        phys_t                 m_pa;
        mat_t                  m_mat;

        tlb_match #(.ENTRY_NUM(ENTRY_NUM)) u_match (
            .entrys    (entrys),
            .asid      (asid),
            .va        (s1_va),
            .hit       (m_hit),
            .hit_idx   (m_idx),
            .multi_hit (m_multi),
            .sel_perm  (m_perm),
            .pa        (m_pa),
            .mat       (m_mat)
        );

        assign s2_adv        = ~s2_valid | resp_ready[gp];
        assign s1_adv        = ~s1_valid | s2_adv;
        assign req_ready[gp] = s1_adv & ~flush;
        assign resp_valid[gp] = s2_valid;
        assign resp[gp]      = s2_resp;

        // Translation result and exception priority for the S1 request.
        always_comb begin
            result = '0;
            if (da_mode) begin
                result.pa  = s1_va;
                result.mat = da_mat;
            end else begin
                result.pa        = m_pa;
                result.mat       = m_mat;
                result.idx       = m_idx;
                result.multi_hit = m_multi;
                result.is_exc    = 1'b1;
                if (m_hit == '0) begin
                    result.ecode = ECODE_TLBR;
                end else if (!m_perm.v) begin
                    case (s1_type)
                        LOOKUP_FETCH: result.ecode = ECODE_PIF;
                        LOOKUP_LOAD:  result.ecode = ECODE_PIL;
                        LOOKUP_STORE: result.ecode = ECODE_PIS;
                        default:      result.ecode = ECODE_PIL;
                    endcase
                end else if (plv > m_perm.plv) begin
                    result.ecode = ECODE_PPI;
                end else if ((s1_type == LOOKUP_STORE) && !m_perm.d) begin
                    result.ecode = ECODE_PME;
                end else begin
                    result.is_exc = 1'b0;
                    result.ecode  = ECODE_NONE;
                end
            end
        end

        // S1 request register; flush wins over acceptance.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid <= 1'b0;
                s1_va    <= '0;
                s1_type  <= LOOKUP_FETCH;
            end else if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= req_valid[gp];
                if (req_valid[gp]) begin
                    s1_va   <= req_va[gp];
                    s1_type <= req_type[gp];
                end
            end
        end

        // S2 result register; holds while the consumer stalls.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_resp  <= '0;
            end else if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_resp <= result;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_lookup_pipe.sv
// Scoreboard bench for tlb_lookup_pipe: directed requests push expected
// responses per port; a monitor pops and compares on each handshake.
module tb_tlb_lookup_pipe;
    import cpu_defs::*;

    logic             clk = 1'b0;
    logic             rst;
    tlb_entry_t       entrys [16];
    asid_t            asid;
    plv_t             plv;
    logic             da_mode;
    mat_t             da_mat;
    logic             flush;
    logic             rv [2];
    logic             rr [2];
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    virt_t            req_va [2];
    tlb_lookup_type_t req_type [2];
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    tlb_resp_t        resp [2];

    tlb_resp_t        exp_q [2][$];
    int               total = 0;
    int               bad = 0;
    int               pops [2];
    logic             held_v [2];
    tlb_resp_t        held_r [2];

    assign req_valid  = {rv[1], rv[0]};
    assign resp_ready = {rr[1], rr[0]};

    always #5 clk = ~clk;

    tlb_lookup_pipe #(.ENTRY_NUM(16), .PORT_NUM(2)) dut (
        .clk(clk), .rst(rst), .entrys(entrys), .asid(asid), .plv(plv),
        .da_mode(da_mode), .da_mat(da_mat), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
        .req_type(req_type), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp(resp)
    );

    function automatic tlb_page_t pg(input logic [19:0] ppn, input plv_t pl,
                                     input mat_t m, input logic d, input logic v);
        tlb_page_t p;
        p.ppn = ppn; p.plv = pl; p.mat = m; p.d = d; p.v = v;
        return p;
    endfunction

    function automatic tlb_entry_t ent(input logic g, input asid_t a, input logic [5:0] ps,
                                       input logic [18:0] vppn, input tlb_page_t p0, input tlb_page_t p1);
        tlb_entry_t e;
        e.e = 1'b1; e.g = g; e.asid = a; e.ps = ps; e.vppn = vppn; e.p0 = p0; e.p1 = p1;
        return e;
    endfunction

    function automatic tlb_resp_t rsp(input phys_t pa, input mat_t m, input ecode_t ec,
                                      input logic exc, input logic mh, input logic [3:0] idx);
        tlb_resp_t r;
        r.pa = pa; r.mat = m; r.ecode = ec; r.is_exc = exc; r.multi_hit = mh; r.idx = idx;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one request on port p until accepted, then record its expectation.
    task automatic drive(input int p, input virt_t va, input tlb_lookup_type_t t, input tlb_resp_t e);
        int n;
        n = 0;
        rv[p] = 1'b1; req_va[p] = va; req_type[p] = t;
        @(negedge clk);
        while (!req_ready[p] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[p]) begin
            check($sformatf("accept_timeout_p%0d", p), 64'(req_ready[p]), 64'd1);
            rv[p] = 1'b0;
        end else begin
            @(posedge clk);
            exp_q[p].push_back(e);
            #1;
            rv[p] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic monitor_loop();
        tlb_resp_t e;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!rst && resp_valid[p]) begin
                    if (!rr[p]) begin
                        if (held_v[p]) check($sformatf("hold_p%0d", p), 64'(resp[p]), 64'(held_r[p]));
                        held_v[p] = 1'b1;
                        held_r[p] = resp[p];
                    end else begin
                        held_v[p] = 1'b0;
                        if (exp_q[p].size() == 0) begin
                            check($sformatf("spurious_p%0d", p), 64'(resp_valid[p]), 64'd0);
                        end else begin
                            e = exp_q[p].pop_front();
                            check($sformatf("resp_p%0d", p), 64'(resp[p]), 64'(e));
                            pops[p]++;
                        end
                    end
                end else begin
                    held_v[p] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int c0;
        rst = 1'b1; flush = 1'b0; da_mode = 1'b0; da_mat = 2'd0;
        asid = 10'd5; plv = 2'd0;
        for (int i = 0; i < 16; i++) entrys[i] = '0;
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0; rr[p] = 1'b1; req_va[p] = '0; req_type[p] = LOOKUP_LOAD;
            pops[p] = 0; held_v[p] = 1'b0; held_r[p] = '0;
        end
        entrys[2] = ent(1'b1, 10'd0, 6'd12, 19'h40000, pg(20'h11111, 2'd3, 2'd1, 1'b1, 1'b1), pg(20'h11111, 2'd3, 2'd1, 1'b1, 1'b1));
        entrys[3] = ent(1'b1, 10'd0, 6'd12, 19'h091A2, pg(20'hAAAAA, 2'd3, 2'd1, 1'b1, 1'b1), pg(20'hAAAAA, 2'd3, 2'd1, 1'b1, 1'b1));
        entrys[5] = ent(1'b1, 10'd0, 6'd21, 19'h40000, pg(20'h22222, 2'd3, 2'd1, 1'b1, 1'b1), pg(20'h22222, 2'd3, 2'd1, 1'b1, 1'b1));
        entrys[6] = ent(1'b0, 10'd5, 6'd21, 19'h00300, pg(20'h55555, 2'd3, 2'd3, 1'b1, 1'b0), pg(20'h12340, 2'd3, 2'd2, 1'b0, 1'b1));
        entrys[7] = ent(1'b1, 10'd0, 6'd21, 19'h00500, pg(20'h00000, 2'd0, 2'd0, 1'b1, 1'b1), pg(20'h00400, 2'd0, 2'd0, 1'b1, 1'b1));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp0", 64'(resp[0]), 64'd0);
        check("rst_resp1", 64'(resp[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(req_ready), 64'd3);
        fork
            monitor_loop();
        join_none
        @(posedge clk); #1;

        // Translation and exception vectors
        drive(0, 32'h1234_5678, LOOKUP_LOAD,  rsp(32'hAAAA_A678, 2'd1, ECODE_NONE, 1'b0, 1'b0, 4'd3));
        drive(1, 32'h0061_2345, LOOKUP_STORE, rsp(32'h1221_2345, 2'd2, ECODE_PME,  1'b1, 1'b0, 4'd6));
        drive(0, 32'h0040_0000, LOOKUP_FETCH, rsp(32'h5540_0000, 2'd3, ECODE_PIF,  1'b1, 1'b0, 4'd6));
        drive(1, 32'h8000_0000, LOOKUP_LOAD,  rsp(32'h1111_1000, 2'd1, ECODE_NONE, 1'b0, 1'b1, 4'd2));
        drive(0, 32'h4000_0000, LOOKUP_LOAD,  rsp(32'h0000_0000, 2'd0, ECODE_TLBR, 1'b1, 1'b0, 4'd0));
        drain();
        plv = 2'd3; asid = 10'd6;
        drive(0, 32'h00A0_1000, LOOKUP_STORE, rsp(32'h0040_1000, 2'd0, ECODE_PPI,  1'b1, 1'b0, 4'd7));
        drive(1, 32'h0061_2345, LOOKUP_LOAD,  rsp(32'h0000_0000, 2'd0, ECODE_TLBR, 1'b1, 1'b0, 4'd0));
        drain();
        plv = 2'd0; asid = 10'd5;

        // Port 0 stalled by resp_ready while port 1 streams
        rr[0] = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    drive(0, 32'h1234_5000 + 32'(k * 4), LOOKUP_LOAD,
                          rsp(32'hAAAA_A000 + 32'(k * 4), 2'd1, ECODE_NONE, 1'b0, 1'b0, 4'd3));
            end
            begin
                for (int k = 0; k < 6; k++)
                    drive(1, 32'h8000_0000 + 32'(k * 16), LOOKUP_LOAD,
                          rsp(32'h1111_1000 + 32'(k * 16), 2'd1, ECODE_NONE, 1'b0, 1'b1, 4'd2));
            end
            begin
                repeat (3) @(negedge clk);
                @(posedge clk);
                c0 = pops[1];
                repeat (3) @(posedge clk);
                #1;
                check("p1_stream_rate", 64'(pops[1] - c0), 64'd3);
                check("p0_stall_valid", 64'(resp_valid[0]), 64'd1);
                check("p0_stall_ready", 64'(req_ready[0]), 64'd0);
                rr[0] = 1'b1;
            end
        join
        drain();

        // Flush with both stages full on both ports
        rr[0] = 1'b0; rr[1] = 1'b0;
        fork
            begin
                drive(0, 32'h1234_5010, LOOKUP_LOAD, rsp(32'hAAAA_A010, 2'd1, ECODE_NONE, 1'b0, 1'b0, 4'd3));
                drive(0, 32'h1234_5020, LOOKUP_LOAD, rsp(32'hAAAA_A020, 2'd1, ECODE_NONE, 1'b0, 1'b0, 4'd3));
            end
            begin
                drive(1, 32'h8000_0020, LOOKUP_LOAD, rsp(32'h1111_1020, 2'd1, ECODE_NONE, 1'b0, 1'b1, 4'd2));
                drive(1, 32'h8000_0030, LOOKUP_LOAD, rsp(32'h1111_1030, 2'd1, ECODE_NONE, 1'b0, 1'b1, 4'd2));
            end
        join
        flush = 1'b1;
        rv[0] = 1'b1; req_va[0] = 32'h1234_5678; req_type[0] = LOOKUP_LOAD;
        @(negedge clk);
        check("flush_ready_full", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("flush_cleared", 64'(resp_valid), 64'd0);
        check("flush_ready_empty", 64'(req_ready), 64'd0);
        exp_q[0].delete(); exp_q[1].delete();
        rr[0] = 1'b1; rr[1] = 1'b1;
        @(posedge clk); #1;
        check("flush_no_accept", 64'(resp_valid), 64'd0);
        flush = 1'b0;
        @(negedge clk);
        check("post_flush_ready", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        exp_q[0].push_back(rsp(32'hAAAA_A678, 2'd1, ECODE_NONE, 1'b0, 1'b0, 4'd3));
        #1;
        rv[0] = 1'b0;
        @(negedge clk);
        check("post_flush_lat1", 64'(resp_valid[0]), 64'd0);
        @(negedge clk);
        check("post_flush_lat2", 64'(resp_valid[0]), 64'd1);
        drain();

        // Direct-address mode with latency check
        da_mode = 1'b1; da_mat = 2'd1;
        drive(0, 32'h1C00_0000, LOOKUP_FETCH, rsp(32'h1C00_0000, 2'd1, ECODE_NONE, 1'b0, 1'b0, 4'd0));
        @(negedge clk);
        check("da_lat1", 64'(resp_valid[0]), 64'd0);
        @(negedge clk);
        check("da_lat2", 64'(resp_valid[0]), 64'd1);
        drain();

        // Reset mid-stream drops in-flight requests
        drive(1, 32'h8000_0000, LOOKUP_LOAD, rsp(32'h8000_0000, 2'd1, ECODE_NONE, 1'b0, 1'b0, 4'd0));
        drive(1, 32'h8000_0010, LOOKUP_LOAD, rsp(32'h8000_0010, 2'd1, ECODE_NONE, 1'b0, 1'b0, 4'd0));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(resp_valid), 64'd0);
        check("midrst_resp1", 64'(resp[1]), 64'd0);
        exp_q[0].delete(); exp_q[1].delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", 64'(req_ready), 64'd3);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_resp", 64'(resp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
